icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch side and the memory controller.
- Serves imemREN/imemaddr requests from the datapath and returns imemload/ihit.
- On a miss, fetches one word through the memory controller's instruction port (iREN/iaddr/iload/iwait), installs it, then serves the hit.
- One-word blocks; sized for the single-cycle and pipelined cores.

Parameters:
- NSETS, 16, number of frames; power of two, >= 2. IDX_W = log2(NSETS).
- PC_INIT, 0, unused for storage; reserved so the top level passes one parameter set to both fetch blocks.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  synchronous, active-high reset (1 = reset); sampled on the CLK rising edge only.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address (word_t); bits [1:0] ignored.
- imemload  out  32  instruction word returned to datapath.
- ihit  out  1  imemload valid this cycle.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address; bits [1:0] = 0.
- iload  in  32  memory read data.
- iwait  in  1  1 = memory busy; data valid in the cycle iwait=0 while iREN=1.

Behaviour:
- Address split: index = imemaddr[IDX_W+1:2]; tag = imemaddr[31:IDX_W+2].
- Storage per frame: valid bit, tag, 32-bit data.
- Reset (nRST=1 at edge):
  - All valid bits cleared; tags and data need not reset.
  - State <= IDLE; latched miss address <= 0.
  - Outputs in the following cycle: ihit=0, iREN=0, iaddr=0, imemload=0.
- FSM states: IDLE, FETCH.
- IDLE:
  - hit = imemREN & valid[index] & (tag[index]==tag).
  - ihit = hit, combinational in the same cycle; imemload = data[index] when hit, else 0.
  - On imemREN & !hit: latch {tag,index} into miss_addr; next state FETCH.
  - iREN=0 in IDLE.
- FETCH:
  - iREN=1; iaddr = {miss_addr,2'b00}; ihit=0; imemload=0.
  - While iwait=1: hold.
  - When iwait=0: write frame[miss index] <= {valid=1, miss tag, iload}; next state IDLE.
- Miss latency: entry cycle + memory wait cycles + 1. The hit is presented the cycle after the fill (no forwarding of iload).
- A frame occupied by a different tag is overwritten on fill (direct-mapped eviction).
- imemREN dropping or imemaddr changing during FETCH:
  - The fill still completes with the latched address.
  - No ihit is generated for the abandoned request.
  - IDLE then evaluates the current request.
- Reset while in FETCH: abort immediately; iREN=0 the next cycle; no frame written even if iwait=0 in the reset cycle.
- Simultaneous fill and lookup cannot occur: lookups happen only in IDLE.
- No write path; self-modifying code is unsupported.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments each cycle ihit=1.
  - miss_count increments on each IDLE->FETCH transition.
  - Both clear on reset and saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Cold miss:
  - Stimulus: reset, then imemREN=1, imemaddr=0x0000_0040, memory iwait=1 for 3 cycles then 0 with iload=0x2002_0005.
  - Required: iREN=1 and iaddr=0x40 for 4 cycles; ihit=1 with imemload=0x2002_0005 on the 5th cycle after the request.
- Hit:
  - Stimulus: re-request 0x40, then 0x42.
  - Required: ihit=1 in the same cycle both times, imemload=0x2002_0005, iREN=0.
- Conflict eviction (NSETS=16):
  - Stimulus: fill 0x40, then request 0x80 (same index 0) with iload=0xDEAD_BEEF, then 0x40 again.
  - Required: 0x80 misses then hits 0xDEADBEEF; 0x40 misses again, iaddr=0x40.
- Abandoned request:
  - Stimulus: during FETCH for 0x100, drop imemREN and set imemaddr=0x200.
  - Required: iaddr stays 0x100 until iwait=0; no ihit; frame for 0x100 is then valid.
- Reset mid-fetch:
  - Stimulus: assert nRST=1 in a FETCH cycle where iwait=0.
  - Required: iREN=0 the next cycle; the subsequent request to the same address misses.
- Stats (ICACHE_STATS_EN):
  - Stimulus: 1 cold miss followed by 3 hits.
  - Required: miss_count=1, hit_count=4 (fill-following hit included).

Source files
------------

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with one-word blocks; `define ICACHE_STATS_EN adds hit/miss counters
module icache_direct #(
  parameter int          NSETS   = 16,
  parameter logic [31:0] PC_INIT = 32'h0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - IDX_W;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t           state_q, state_d;
  logic [29:0]      miss_addr_q, miss_addr_d;
  logic [NSETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [NSETS];
  logic [31:0]      data_q [NSETS];
  logic [IDX_W-1:0] idx, miss_idx;
  logic [TAG_W-1:0] tag, miss_tag;
  logic             hit, fill, miss;
  logic             unused;
  assign unused   = ^{PC_INIT, imemaddr[1:0]};
  assign idx      = imemaddr[IDX_W+1:2];
  assign tag      = imemaddr[31:IDX_W+2];
  assign miss_idx = miss_addr_q[IDX_W-1:0];
  assign miss_tag = miss_addr_q[29:IDX_W];
  always_comb begin
    hit         = state_q == IDLE && imemREN && valid_q[idx] && tag_q[idx] == tag;
    miss        = state_q == IDLE && imemREN && !hit;
    fill        = state_q == FETCH && !iwait;
    ihit        = hit;
    imemload    = hit ? data_q[idx] : '0;
    iREN        = state_q == FETCH;
    iaddr       = iREN ? {miss_addr_q, 2'b00} : '0;
    miss_addr_d = miss ? imemaddr[31:2] : miss_addr_q;
    state_d     = state_q == IDLE ? (miss ? FETCH : IDLE) : (iwait ? FETCH : IDLE);
    valid_d     = valid_q;
    if (fill) valid_d[miss_idx] = 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
    end
  end
  // a reset in the fill cycle wins: the frame keeps its old contents
  always_ff @(posedge CLK) begin
    if (fill && !nRST) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= iload;
    end
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, hit && hit_count_q != '1};
    miss_count_d = miss_count_q + {31'd0, miss && miss_count_q != '1};
  end
  always_ff @(posedge CLK) begin
    if (nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed test-plan sequences plus randomized traffic checked against a behavioural cache model
module tb_icache_direct;
  localparam int NSETS = 16;
  logic        CLK = 0, nRST = 0, imemREN = 0, iwait = 0;
  logic [31:0] imemaddr = 0, iload = 0;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;
  int          tests = 0, fails = 0;
  bit          started = 0, m_busy = 0;
  logic [31:0] m_miss = 0;
  bit          m_valid [NSETS];
  logic [31:0] m_tag [NSETS], m_data [NSETS];
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  longint      m_hits = 0, m_misses = 0;
`endif

  icache_direct #(.NSETS(NSETS), .PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .imemload(imemload), .ihit(ihit), .iREN(iREN), .iaddr(iaddr),
    .iload(iload), .iwait(iwait)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic int idx_of(logic [31:0] a);
    return int'((a / 4) % NSETS);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] a);
    return a / (4 * NSETS);
  endfunction

  function automatic bit exp_hit();
    return !m_busy && imemREN && m_valid[idx_of(imemaddr)] && m_tag[idx_of(imemaddr)] == tag_of(imemaddr);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model state advances on each rising edge from the inputs seen there
  always @(posedge CLK) begin
    bit h;
    h = exp_hit();
    if (nRST) begin
      started = 1;
      m_busy  = 0;
      m_miss  = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
`ifdef ICACHE_STATS_EN
      m_hits = 0;
      m_misses = 0;
`endif
    end else if (started) begin
`ifdef ICACHE_STATS_EN
      if (h && m_hits < 64'hFFFF_FFFF) m_hits++;
      if (!m_busy && imemREN && !h && m_misses < 64'hFFFF_FFFF) m_misses++;
`endif
      if (m_busy) begin
        if (!iwait) begin
          m_valid[idx_of(m_miss)] = 1;
          m_tag[idx_of(m_miss)]   = tag_of(m_miss);
          m_data[idx_of(m_miss)]  = iload;
          m_busy = 0;
        end
      end else if (imemREN && !h) begin
        m_busy = 1;
        m_miss = imemaddr & ~32'd3;
      end
    end
  end

  always @(negedge CLK) begin
    bit h;
    if (started) begin
      h = exp_hit();
      chk("ihit", {31'd0, ihit}, {31'd0, h});
      chk("imemload", imemload, h ? m_data[idx_of(imemaddr)] : 32'd0);
      chk("iREN", {31'd0, iREN}, {31'd0, m_busy});
      if (m_busy) chk("iaddr", iaddr, m_miss);
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, m_hits[31:0]);
      chk("miss_count", miss_count, m_misses[31:0]);
`endif
    end
  end

  task automatic go(bit ren, logic [31:0] a, bit w, logic [31:0] ld, bit r = 0);
    @(posedge CLK);
    #1;
    imemREN = ren; imemaddr = a; iwait = w; iload = ld; nRST = r;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    go(0, 0, 0, 0, 1);
    go(0, 0, 0, 0);
    chk("rst_ihit", {31'd0, ihit}, 0);
    chk("rst_iREN", {31'd0, iREN}, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_imemload", imemload, 0);
    // cold miss at 0x40 with three busy memory cycles
    go(1, 32'h40, 1, 0);
    chk("cold_req_ihit", {31'd0, ihit}, 0);
    for (int k = 0; k < 4; k++) begin
      go(1, 32'h40, k < 3, 32'h2002_0005);
      chk("cold_iREN", {31'd0, iREN}, 1);
      chk("cold_iaddr", iaddr, 32'h40);
      chk("cold_ihit", {31'd0, ihit}, 0);
    end
    go(1, 32'h40, 0, 0);
    chk("cold_fill_hit", {31'd0, ihit}, 1);
    chk("cold_fill_data", imemload, 32'h2002_0005);
    go(1, 32'h42, 0, 0);
    chk("hit42", {31'd0, ihit}, 1);
    chk("hit42_data", imemload, 32'h2002_0005);
    chk("hit42_iREN", {31'd0, iREN}, 0);
    go(1, 32'h40, 0, 0);
    chk("hit40", {31'd0, ihit}, 1);
    go(1, 32'h40, 0, 0);
    go(0, 32'h40, 0, 0);
`ifdef ICACHE_STATS_EN
    chk("stats_hits", hit_count, 4);
    chk("stats_misses", miss_count, 1);
`endif
    // conflict eviction on index 0
    go(1, 32'h80, 1, 32'hDEAD_BEEF);
    chk("evict_miss", {31'd0, ihit}, 0);
    go(1, 32'h80, 0, 32'hDEAD_BEEF);
    chk("evict_iaddr", iaddr, 32'h80);
    go(1, 32'h80, 0, 0);
    chk("evict_hit", {31'd0, ihit}, 1);
    chk("evict_data", imemload, 32'hDEAD_BEEF);
    go(1, 32'h40, 1, 0);
    chk("evicted_miss", {31'd0, ihit}, 0);
    go(1, 32'h40, 0, 32'h2002_0005);
    chk("evicted_iaddr", iaddr, 32'h40);
    go(1, 32'h40, 0, 0);
    chk("refill_hit", {31'd0, ihit}, 1);
    // abandoned request
    go(1, 32'h100, 1, 0);
    go(0, 32'h200, 1, 0);
    chk("aband_iaddr", iaddr, 32'h100);
    go(0, 32'h200, 1, 0);
    chk("aband_iaddr2", iaddr, 32'h100);
    go(0, 32'h200, 0, 32'hCAFE_0100);
    chk("aband_ihit", {31'd0, ihit}, 0);
    go(0, 32'h200, 0, 0);
    chk("aband_idle_ihit", {31'd0, ihit}, 0);
    chk("aband_idle_iREN", {31'd0, iREN}, 0);
    go(1, 32'h100, 0, 0);
    chk("aband_later_hit", {31'd0, ihit}, 1);
    chk("aband_later_data", imemload, 32'hCAFE_0100);
    // reset in a fill cycle discards the fill
    go(1, 32'h300, 1, 0);
    go(1, 32'h300, 0, 32'hBAD0_0300, 1);
    chk("rstmid_iREN_before", {31'd0, iREN}, 1);
    go(1, 32'h300, 1, 0);
    chk("rstmid_iREN_after", {31'd0, iREN}, 0);
    chk("rstmid_miss", {31'd0, ihit}, 0);
    go(1, 32'h300, 0, 32'h1234_5678);
    chk("rstmid_refetch", iaddr, 32'h300);
    go(1, 32'h300, 0, 0);
    chk("rstmid_hit_data", imemload, 32'h1234_5678);
    // randomized traffic over a small address pool so hits and evictions both occur
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      go($urandom_range(0, 9) < 8, a, $urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 249) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
